// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the counter sequencer: FSM encoding and program-word layout.
// Program word layout, MSB first: {min[W], max[W], mode, reps[3]}.
package cnt_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    NEXT = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int REPS_LSB = 0;
  localparam int REPS_W   = 3;
  localparam int MODE_BIT = 3;
  localparam int MAX_LSB  = 4;

  // min sits directly above max, so its offset depends on the counter width
  function automatic int min_lsb(input int w);
    return MAX_LSB + w;
  endfunction

endpackage

// File: rtl/cnt_seq_table.sv
// Program table: NSEG words, synchronous write, combinational read.
// Also flags every entry whose min exceeds its max.
module cnt_seq_table
  import cnt_seq_pkg::*;
#(
  parameter int W    = 4,
  parameter int NSEG = 4,
  localparam int AW  = $clog2(NSEG),
  localparam int DW  = 2*W + 4
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   wr_addr,
  input  logic [DW-1:0]   wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [DW-1:0]   rd_data,
  output logic [NSEG-1:0] bad
);

  localparam int MIN_LSB = min_lsb(W);

  // No reset: the program survives a controller reset.
  logic [DW-1:0] mem [NSEG];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

  always_comb begin
    bad = '0;
    for (int i = 0; i < NSEG; i++) begin
      bad[i] = mem[i][MIN_LSB +: W] > mem[i][MAX_LSB +: W];
    end
  end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Sequencer that steps an external up/down counter through a table of segments,
// each run for reps+1 passes between its min and max bounds.
//
// state | meaning
// IDLE  | waiting for start; table writable
// LOAD  | one cycle, counter loaded with segment start value
// RUN   | counting; passes counted on terminal value while enabled
// NEXT  | one cycle, advance segment or finish
// DONE  | one-cycle done pulse
module cnt_seq_ctrl
  import cnt_seq_pkg::*;
#(
  parameter int W    = 4,
  parameter int NSEG = 4,
  localparam int AW  = $clog2(NSEG),
  localparam int DW  = 2*W + 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          hold,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] nseg_m1,
  input  logic [W-1:0]  cnt_out,
  output logic          cnt_load,
  output logic          cnt_ss,
  output logic          cnt_mode,
  output logic [W-1:0]  cnt_min,
  output logic [W-1:0]  cnt_max,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] seg_idx,
  output logic          cfg_err
);

  localparam int MIN_LSB = min_lsb(W);

  state_t              state;
  logic [REPS_W-1:0]   pass_cnt;
  logic [REPS_W-1:0]   reps;
  logic                armed;
  logic [AW-1:0]       rd_addr;
  logic [DW-1:0]       rd_data;
  logic [NSEG-1:0]     bad;
  logic                any_bad;
  logic                terminal;
  logic [W-1:0]        seg_min;
  logic [W-1:0]        seg_max;
  logic                seg_mode;
  logic [REPS_W-1:0]   seg_reps;

  // Read ahead so the bounds are already registered when LOAD begins.
  always_comb begin
    rd_addr = seg_idx;
    if (state == IDLE)      rd_addr = '0;
    else if (state == NEXT) rd_addr = seg_idx + AW'(1);
  end

  cnt_seq_table #(.W(W), .NSEG(NSEG)) u_table (
    .clk     (clk),
    .we      (wr_en && (state == IDLE)),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .bad     (bad)
  );

  assign seg_min  = rd_data[MIN_LSB +: W];
  assign seg_max  = rd_data[MAX_LSB +: W];
  assign seg_mode = rd_data[MODE_BIT];
  assign seg_reps = rd_data[REPS_LSB +: REPS_W];

  always_comb begin
    any_bad = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      if ((AW'(i) <= nseg_m1) && bad[i]) any_bad = 1'b1;
    end
  end

  assign terminal = cnt_mode ? (cnt_out == cnt_max) : (cnt_out == cnt_min);

  assign cnt_load = (state == LOAD);
  assign cnt_ss   = (state == RUN) && !hold;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      seg_idx  <= '0;
      pass_cnt <= '0;
      reps     <= '0;
      cnt_mode <= 1'b0;
      cnt_min  <= '0;
      cnt_max  <= '0;
      cfg_err  <= 1'b0;
      armed    <= 1'b1;
    end else if (abort && (state != IDLE)) begin
      state    <= IDLE;
      seg_idx  <= '0;
      pass_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start must be seen low before it can launch again
          if (!start) begin
            armed <= 1'b1;
          end else if (armed && !abort) begin
            if (any_bad) begin
              cfg_err <= 1'b1;
            end else begin
              cfg_err  <= 1'b0;
              armed    <= 1'b0;
              seg_idx  <= '0;
              cnt_min  <= seg_min;
              cnt_max  <= seg_max;
              cnt_mode <= seg_mode;
              reps     <= seg_reps;
              state    <= LOAD;
            end
          end
        end
        LOAD: begin
          pass_cnt <= '0;
          state    <= RUN;
        end
        RUN: begin
          if (cnt_ss && terminal) begin
            if (pass_cnt == reps) state <= NEXT;
            else                  pass_cnt <= pass_cnt + REPS_W'(1);
          end
        end
        NEXT: begin
          if (seg_idx == nseg_m1) begin
            state <= DONE;
          end else begin
            seg_idx  <= seg_idx + AW'(1);
            cnt_min  <= seg_min;
            cnt_max  <= seg_max;
            cnt_mode <= seg_mode;
            reps     <= seg_reps;
            state    <= LOAD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: drives an external counter model and checks against a
// segment/pass model built from the table contents the bench itself wrote.
module tb_cnt_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, abort = 1'b0, hold = 1'b0, wr_en = 1'b0;
  logic [1:0]  wr_addr = '0, nseg_m1 = '0;
  logic [11:0] wr_data = '0;
  logic [3:0]  cnt_out;
  logic        cnt_load, cnt_ss, cnt_mode, busy, done, cfg_err;
  logic [3:0]  cnt_min, cnt_max;
  logic [1:0]  seg_idx;

  int n_cmp = 0;
  int n_err = 0;

  cnt_seq_ctrl #(.W(4), .NSEG(4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .nseg_m1(nseg_m1),
    .cnt_out(cnt_out), .cnt_load(cnt_load), .cnt_ss(cnt_ss), .cnt_mode(cnt_mode),
    .cnt_min(cnt_min), .cnt_max(cnt_max), .busy(busy), .done(done),
    .seg_idx(seg_idx), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  // External wrapping up/down counter driven by the controller.
  always @(posedge clk or negedge rst) begin
    if (!rst)          cnt_out <= '0;
    else if (cnt_load) cnt_out <= cnt_mode ? cnt_min : cnt_max;
    else if (cnt_ss) begin
      if (cnt_mode) cnt_out <= (cnt_out == cnt_max) ? cnt_min : cnt_out + 4'd1;
      else          cnt_out <= (cnt_out == cnt_min) ? cnt_max : cnt_out - 4'd1;
    end
  end

  int tmin[4], tmax[4], tmode[4], treps[4];

  typedef struct { int val; int mn; int mx; int md; int seg; } obs_t;
  obs_t exp_q[$];
  obs_t obs_q[$];

  typedef struct {
    logic start; logic hold;
    logic busy; logic load; logic ss; logic done; logic chk_cnt; int cnt;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_entry(input int a, input int mn, input int mx, input int md, input int rp);
    wr_addr = 2'(a);
    wr_data = {4'(mn), 4'(mx), 1'(md), 3'(rp)};
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    tmin[a] = mn; tmax[a] = mx; tmode[a] = md; treps[a] = rp;
  endtask

  // Every value the counter should present while enabled, in order.
  task automatic build_exp(input int n);
    exp_q.delete();
    for (int s = 0; s <= n; s++)
      for (int p = 0; p <= treps[s]; p++)
        for (int k = 0; k <= tmax[s] - tmin[s]; k++)
          exp_q.push_back('{tmode[s] != 0 ? tmin[s] + k : tmax[s] - k,
                            tmin[s], tmax[s], tmode[s], s});
  endtask

  function automatic int exp_busy(input int n);
    int t = 1;
    for (int s = 0; s <= n; s++) t += 2 + (treps[s] + 1) * (tmax[s] - tmin[s] + 1);
    return t;
  endfunction

  task automatic run_prog(input int pct, output int bc, output int nd, output int nl);
    int k = 0;
    bc = 0; nd = 0; nl = 0;
    obs_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && k < 3000) begin
      bc++;
      if (cnt_load) nl++;
      if (done) nd++;
      hold = (pct > 0) && ($urandom_range(99) < pct);
      #1;
      if (hold) chk("hold_blocks_ss", int'(cnt_ss), 0);
      if (cnt_ss) obs_q.push_back('{int'(cnt_out), int'(cnt_min), int'(cnt_max),
                                    int'(cnt_mode), int'(seg_idx)});
      tick();
      k++;
    end
    hold = 1'b0;
    chk("run_timeout", int'(k >= 3000), 0);
  endtask

  task automatic check_prog(input int n, input int pct, input string tag);
    int bc, nd, nl, m;
    run_prog(pct, bc, nd, nl);
    build_exp(n);
    chk({tag, "_nvals"}, obs_q.size(), exp_q.size());
    m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      chk($sformatf("%s_val%0d", tag, i), obs_q[i].val, exp_q[i].val);
      chk($sformatf("%s_min%0d", tag, i), obs_q[i].mn, exp_q[i].mn);
      chk($sformatf("%s_max%0d", tag, i), obs_q[i].mx, exp_q[i].mx);
      chk($sformatf("%s_mode%0d", tag, i), obs_q[i].md, exp_q[i].md);
      chk($sformatf("%s_seg%0d", tag, i), obs_q[i].seg, exp_q[i].seg);
    end
    chk({tag, "_done_pulses"}, nd, 1);
    chk({tag, "_load_pulses"}, nl, n + 1);
    if (pct == 0) chk({tag, "_busy_cycles"}, bc, exp_busy(n));
    tick();
  endtask

  // Entry0 = {2,5,up,0}, single segment, hold asserted where it must be ignored.
  task automatic run_vectors(input string tag);
    for (int i = 0; i < 8; i++) begin
      start = vt[i].start;
      hold  = vt[i].hold;
      tick();
      chk($sformatf("%s_v%0d_busy", tag, i), int'(busy), int'(vt[i].busy));
      chk($sformatf("%s_v%0d_load", tag, i), int'(cnt_load), int'(vt[i].load));
      chk($sformatf("%s_v%0d_ss", tag, i), int'(cnt_ss), int'(vt[i].ss));
      chk($sformatf("%s_v%0d_done", tag, i), int'(done), int'(vt[i].done));
      if (vt[i].chk_cnt) chk($sformatf("%s_v%0d_cnt", tag, i), int'(cnt_out), vt[i].cnt);
    end
    start = 1'b0;
    hold  = 1'b0;
    tick();
  endtask

  task automatic wait_run_val(input int v, input string tag);
    int k = 0;
    while (!(cnt_ss && int'(cnt_out) == v) && k < 100) begin
      tick();
      k++;
    end
    chk({tag, "_wait_timeout"}, int'(k >= 100), 0);
  endtask

  initial begin
    int k, bc, nh, n;
    //          start hold busy load ss done chk cnt
    vt[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2};
    vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 3};
    vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5};
    vt[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
    vt[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vt[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    #2 rst = 1'b0;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_load", int'(cnt_load), 0);
    chk("rst_ss", int'(cnt_ss), 0);
    chk("rst_min", int'(cnt_min), 0);
    chk("rst_cfg_err", int'(cfg_err), 0);
    #10 rst = 1'b1;
    tick();

    // Basic single-segment timing
    nseg_m1 = 2'd0;
    wr_entry(0, 2, 5, 1, 0);
    run_vectors("basic");

    // Bad entry inside range: rejected, sticky error
    wr_entry(0, 9, 7, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("bad_cfg_err", int'(cfg_err), 1);
    for (int i = 0; i < 4; i++) begin
      chk("bad_busy", int'(busy), 0);
      chk("bad_load", int'(cnt_load), 0);
      tick();
    end
    chk("bad_cfg_sticky", int'(cfg_err), 1);

    // Bad entry beyond nseg_m1 is ignored; successful start clears the error
    wr_entry(0, 1, 4, 1, 0);
    wr_entry(1, 9, 7, 0, 0);
    check_prog(0, 0, "outside_bad");
    chk("cfg_err_cleared", int'(cfg_err), 0);

    // Two segments, up with repeat then down
    wr_entry(0, 0, 3, 1, 1);
    wr_entry(1, 4, 6, 0, 0);
    nseg_m1 = 2'd1;
    check_prog(1, 0, "two_seg");

    // Hold for three cycles at cnt_out=3
    nseg_m1 = 2'd0;
    wr_entry(0, 1, 4, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    bc = 1; nh = 0; k = 0;
    while (busy && k < 100) begin
      hold = 1'b0;
      #1;
      if (cnt_ss && cnt_out == 4'd3 && nh < 3) begin
        hold = 1'b1;
        nh++;
        #1;
        chk("hold_ss", int'(cnt_ss), 0);
        chk("hold_cnt", int'(cnt_out), 3);
      end
      tick();
      k++;
      if (busy) bc++;
    end
    hold = 1'b0;
    chk("hold_count", nh, 3);
    chk("hold_busy_cycles", bc, 10);
    tick();

    // start held high does not relaunch until seen low
    start = 1'b1;
    tick();
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    chk("held_timeout", int'(k >= 50), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("held_no_relaunch", int'(busy), 0);
    end
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    chk("relaunch_busy", int'(busy), 1);
    start = 1'b0;
    k = 0;
    while (busy && k < 50) begin
      tick();
      k++;
    end
    tick();

    // abort beats start in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    chk("abort_beats_start", int'(busy), 0);
    start = 1'b0;
    abort = 1'b0;
    tick();

    // Abort mid-run, with a table write attempted while busy
    wr_entry(0, 0, 3, 1, 1);
    wr_entry(1, 4, 6, 0, 0);
    nseg_m1 = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run_val(2, "abort");
    chk("abort_seg", int'(seg_idx), 0);
    wr_en = 1'b1;
    wr_addr = 2'd0;
    wr_data = 12'hFA5;
    abort = 1'b1;
    tick();
    wr_en = 1'b0;
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_ss", int'(cnt_ss), 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_done", int'(done), 0);
      tick();
    end
    check_prog(1, 0, "after_abort");

    // Asynchronous reset mid-run, table retained
    nseg_m1 = 2'd0;
    wr_entry(0, 2, 5, 1, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run_val(3, "rstmid");
    #2 rst = 1'b0;
    #1;
    chk("rstmid_busy", int'(busy), 0);
    chk("rstmid_ss", int'(cnt_ss), 0);
    chk("rstmid_mode", int'(cnt_mode), 0);
    chk("rstmid_max", int'(cnt_max), 0);
    chk("rstmid_min", int'(cnt_min), 0);
    chk("rstmid_seg", int'(seg_idx), 0);
    #2 rst = 1'b1;
    tick();
    run_vectors("rerun");

    // Randomized programs
    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(3);
      nseg_m1 = 2'(n);
      for (int s = 0; s < 4; s++) begin
        int mn, mx;
        mn = $urandom_range(15);
        mx = $urandom_range(15, mn);
        wr_entry(s, mn, mx, $urandom_range(1), $urandom_range(3));
      end
      check_prog(n, (t % 2 == 0) ? 0 : 30, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
